// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order word reads and buffers
// returned instructions with their PCs for the ID stage. Handles redirects and back-pressure.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        im_req_o,
    output logic [31:0] im_addr_o,
    input  logic        im_gnt_i,
    input  logic        im_rvalid_i,
    input  logic [31:0] im_rdata_i,
    input  logic        ex_redirect_i,
    input  logic [31:0] ex_redirect_pc_i,
    input  logic        id_stall_i,
    output logic        id_valid_o,
    output logic [31:0] id_insn_o,
    output logic [31:0] id_pc_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 2) ? 2 : 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    localparam cnt_t        DepthC = cnt_t'(DEPTH);
    localparam ptr_t        LastP  = ptr_t'(DEPTH - 1);
    localparam logic [31:0] Nop    = 32'h0000_0013;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LastP) ? '0 : p + ptr_t'(1);
    endfunction

    logic [31:0] pc_q, pc_d;
    logic [31:0] pcq_q [DEPTH];
    logic [31:0] pcq_d [DEPTH];
    ptr_t        pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
    logic [31:0] fifo_pc_q [DEPTH];
    logic [31:0] fifo_pc_d [DEPTH];
    logic [31:0] fifo_insn_q [DEPTH];
    logic [31:0] fifo_insn_d [DEPTH];
    ptr_t        fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    cnt_t        count_q, count_d;
    cnt_t        outstanding_q, outstanding_d;
    cnt_t        discard_q, discard_d;

    logic        pop, grant, rsp, keep;
    cnt_t        occ;
    logic [31:0] redirect_pc;

    assign id_valid_o  = (count_q != '0);
    assign id_insn_o   = id_valid_o ? fifo_insn_q[fifo_rd_q] : Nop;
    assign id_pc_o     = id_valid_o ? fifo_pc_q[fifo_rd_q] : 32'h0;
    assign im_addr_o   = pc_q;
    assign redirect_pc = ex_redirect_pc_i & 32'hFFFF_FFFC;

    always_comb begin
        pop   = id_valid_o & ~id_stall_i;
        occ   = outstanding_q + count_q - cnt_t'(pop);
        // Held low while in reset so the request reads 0 as soon as reset asserts.
        im_req_o = rst_n & ~ex_redirect_i & (occ < DepthC);
        grant = im_req_o & im_gnt_i;
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp   = im_rvalid_i & (outstanding_q != '0);
        keep  = rsp & (discard_q == '0) & ~ex_redirect_i;

        pc_d          = pc_q;
        pcq_d         = pcq_q;
        pcq_wr_d      = pcq_wr_q;
        pcq_rd_d      = pcq_rd_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_insn_d   = fifo_insn_q;
        fifo_wr_d     = fifo_wr_q;
        fifo_rd_d     = fifo_rd_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        if (grant) begin
            pcq_d[pcq_wr_q] = pc_q;
            pcq_wr_d        = ptr_inc(pcq_wr_q);
            pc_d            = pc_q + 32'd4;
        end
        if (rsp) begin
            pcq_rd_d = ptr_inc(pcq_rd_q);
        end

        if (grant && !rsp) begin
            outstanding_d = outstanding_q + cnt_t'(1);
        end else if (!grant && rsp) begin
            outstanding_d = outstanding_q - cnt_t'(1);
        end

        if (ex_redirect_i) begin
            pc_d      = redirect_pc;
            // Every request still in flight after this cycle is stale.
            discard_d = outstanding_q - cnt_t'(rsp);
            count_d   = '0;
            fifo_wr_d = '0;
            fifo_rd_d = '0;
        end else begin
            if (rsp && discard_q != '0) begin
                discard_d = discard_q - cnt_t'(1);
            end
            if (keep) begin
                fifo_pc_d[fifo_wr_q]   = pcq_q[pcq_rd_q];
                fifo_insn_d[fifo_wr_q] = im_rdata_i;
                fifo_wr_d              = ptr_inc(fifo_wr_q);
            end
            if (pop) begin
                fifo_rd_d = ptr_inc(fifo_rd_q);
            end
            if (keep && !pop) begin
                count_d = count_q + cnt_t'(1);
            end else if (!keep && pop) begin
                count_d = count_q - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            pcq_wr_q      <= '0;
            pcq_rd_q      <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pcq_q[i]       <= '0;
                fifo_pc_q[i]   <= '0;
                fifo_insn_q[i] <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            pcq_q         <= pcq_d;
            pcq_wr_q      <= pcq_wr_d;
            pcq_rd_q      <= pcq_rd_d;
            fifo_pc_q     <= fifo_pc_d;
            fifo_insn_q   <= fifo_insn_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

endmodule
